proc_param: RTL and testbench

//  Parametrised multi-cycle processor; next generation of our 8-bit 4-op proc.

---
 rtl/proc_param_pkg.sv | 36 +++
 rtl/proc_alu.sv | 46 ++++
 rtl/proc_param.sv | 125 ++++++++++++
 tb/tb_proc_param.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/proc_param_pkg.sv
// proc_param_pkg: shared definitions for the parameterised multi-cycle processor.
//   - opcode encodings (3-bit op field)
//   - step counter encodings T0..T3
//   - instruction field slicing helpers (independent of DATA_W / RAW)
package proc_param_pkg;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_MVNZ = 3'b111;

    typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} step_t;

    // Fields are taken from a zero-extended copy of the instruction word so
    // the helpers stay width-agnostic; raw is the register index width.
    function automatic logic [2:0] f_op(input logic [63:0] w, input int raw);
        return w[2*raw +: 3];
    endfunction

    function automatic logic [7:0] f_rx(input logic [63:0] w, input int raw);
        logic [63:0] m;
        m = (w >> raw) & ((64'd1 << raw) - 64'd1);
        return m[7:0];
    endfunction

    function automatic logic [7:0] f_ry(input logic [63:0] w, input int raw);
        logic [63:0] m;
        m = w & ((64'd1 << raw) - 64'd1);
        return m[7:0];
    endfunction

endpackage

// File: rtl/proc_alu.sv
// proc_alu: combinational ALU for proc_param.
//   a, b   : operands (A register, bus value)
//   op     : opcode; only ALU opcodes produce a result, others give 0
//   result : a op b, modulo 2^DATA_W
//   c      : carry-out (add), borrow (sub), 0 for logic ops
//   z      : result == 0
module proc_alu
    import proc_param_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        op,
    output logic [DATA_W-1:0] result,
    output logic              c,
    output logic              z
);

    logic [DATA_W:0] ext;

    always_comb begin
        ext    = '0;
        result = '0;
        c      = 1'b0;
        case (op)
            OP_ADD: begin
                ext    = {1'b0, a} + {1'b0, b};
                result = ext[DATA_W-1:0];
                c      = ext[DATA_W];
            end
            OP_SUB: begin
                // top bit of the widened difference is the unsigned borrow
                ext    = {1'b0, a} - {1'b0, b};
                result = ext[DATA_W-1:0];
                c      = ext[DATA_W];
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            default: result = '0;
        endcase
        z = (result == '0);
    end

endmodule

// File: rtl/proc_param.sv
// proc_param: parameterised multi-cycle processor on a shared bus.
// Ports:
//   Clock, Reset : rising-edge clock, asynchronous active-high reset
//   DIN          : instruction word in T0, immediate in mvi T1
//   Run          : start request, only looked at in T0
//   Done         : last cycle of the current instruction (combinational)
//   Busy         : step counter is not T0
//   Bus          : internal bus value
//   Rflat        : register file, Rk = Rflat[k*DATA_W +: DATA_W]
//   Flags        : {C,Z}, updated only by ALU ops in T3
//   Counter      : step counter T0..T3
//   Clear        : Done | Reset
module proc_param
    import proc_param_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int RAW    = $clog2(NREG)
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [DATA_W-1:0]        DIN,
    input  logic                     Run,
    output logic                     Done,
    output logic                     Busy,
    output logic [DATA_W-1:0]        Bus,
    output logic [NREG*DATA_W-1:0]   Rflat,
    output logic [1:0]               Flags,
    output logic [1:0]               Counter,
    output logic                     Clear
);

    step_t                         step;
    logic [DATA_W-1:0]             ir, a, g;
    logic [NREG-1:0][DATA_W-1:0]   rf;
    logic [1:0]                    flags;
    logic [1:0]                    gflags;   // {C,Z} computed with G, committed in T3

    logic [2:0]        op;
    logic [RAW-1:0]    rx, ry;
    logic              mv_cls;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c, alu_z;

    assign op     = f_op(64'(ir), RAW);
    assign rx     = RAW'(f_rx(64'(ir), RAW));
    assign ry     = RAW'(f_ry(64'(ir), RAW));
    assign mv_cls = (op == OP_MV) || (op == OP_MVI) || (op == OP_MVNZ);

    // A is operand a, the bus (Ry in T2) is operand b.
    proc_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (a),
        .b      (Bus),
        .op     (op),
        .result (alu_res),
        .c      (alu_c),
        .z      (alu_z)
    );

    always_comb begin
        Bus = '0;
        case (step)
            T0: Bus = '0;
            T1: begin
                if (op == OP_MVI)  Bus = DIN;
                else if (mv_cls)   Bus = rf[ry];
                else               Bus = rf[rx];
            end
            T2: Bus = rf[ry];
            T3: Bus = g;
            default: Bus = '0;
        endcase
    end

    assign Done    = ((step == T1) && mv_cls) || (step == T3);
    assign Busy    = (step != T0);
    assign Counter = step;
    assign Flags   = flags;
    assign Clear   = Done | Reset;
    assign Rflat   = rf;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            step   <= T0;
            ir     <= '0;
            a      <= '0;
            g      <= '0;
            rf     <= '0;
            flags  <= '0;
            gflags <= '0;
        end else begin
            case (step)
                T0: begin
                    if (Run) begin
                        ir   <= DIN;
                        step <= T1;
                    end
                end
                T1: begin
                    if (mv_cls) begin
                        // mvnz suppresses the write while Z is set
                        if (!(op == OP_MVNZ && flags[0]))
                            rf[rx] <= Bus;
                        step <= T0;
                    end else begin
                        a    <= Bus;
                        step <= T2;
                    end
                end
                T2: begin
                    g      <= alu_res;
                    gflags <= {alu_c, alu_z};
                    step   <= T3;
                end
                T3: begin
                    rf[rx] <= g;
                    flags  <= gflags;
                    step   <= T0;
                end
                default: step <= T0;
            endcase
        end
    end

endmodule

// File: tb/tb_proc_param.sv
// tb_proc_param: self-checking bench for proc_param (DATA_W=16, NREG=8).
// Directed scenarios followed by randomized instructions against a
// behavioural model of the instruction set.
module tb_proc_param;

    localparam int DW = 16;
    localparam int NR = 8;

    logic              Clock = 1'b0;
    logic              Reset;
    logic [DW-1:0]     DIN;
    logic              Run;
    logic              Done, Busy, Clear;
    logic [DW-1:0]     Bus;
    logic [NR*DW-1:0]  Rflat;
    logic [1:0]        Flags, Counter;

    proc_param #(.DATA_W(DW), .NREG(NR)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .DIN     (DIN),
        .Run     (Run),
        .Done    (Done),
        .Busy    (Busy),
        .Bus     (Bus),
        .Rflat   (Rflat),
        .Flags   (Flags),
        .Counter (Counter),
        .Clear   (Clear)
    );

    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;

    // reference state: registers and {C,Z}
    logic [DW-1:0] m_r [NR];
    logic          m_c, m_z;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] m_flat();
        logic [127:0] f;
        f = '0;
        for (int k = 0; k < NR; k++) f[k*DW +: DW] = m_r[k];
        return f;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < NR; k++) m_r[k] = '0;
        m_c = 1'b0;
        m_z = 1'b0;
    endtask

    // Applies one instruction to the model; returns the bus value seen at
    // Done and the number of cycles from the Run edge to Done.
    task automatic model(input logic [DW-1:0] ins, input logic [DW-1:0] imm,
                         output logic [DW-1:0] bus, output int lat);
        int x, y;
        logic [DW:0]   full;
        logic [DW-1:0] res, vx, vy;
        logic          c;
        x  = int'(ins[5:3]);
        y  = int'(ins[2:0]);
        vx = m_r[x];
        vy = m_r[y];
        c  = 1'b0;
        res = '0;
        lat = 3;
        case (ins[8:6])
            3'd0: begin bus = vy;  m_r[x] = vy;  lat = 1; end
            3'd1: begin bus = imm; m_r[x] = imm; lat = 1; end
            3'd7: begin bus = vy; if (!m_z) m_r[x] = vy; lat = 1; end
            default: begin
                case (ins[8:6])
                    3'd2: begin full = {1'b0, vx} + {1'b0, vy}; res = full[DW-1:0]; c = full[DW]; end
                    3'd3: begin res = vx - vy; c = (vx < vy); end
                    3'd4: res = vx & vy;
                    3'd5: res = vx | vy;
                    default: res = vx ^ vy;
                endcase
                m_r[x] = res;
                m_c    = c;
                m_z    = (res == '0);
                bus    = res;
            end
        endcase
    endtask

    // Issues one instruction, checks latency and bus at Done, then the
    // architectural state in the following T0 cycle.
    task automatic exec(input string tag, input logic [DW-1:0] ins, input logic [DW-1:0] imm);
        logic [DW-1:0] eb;
        int lat, n;
        model(ins, imm, eb, lat);
        @(negedge Clock);
        DIN = ins;
        Run = 1'b1;
        @(negedge Clock);
        Run = 1'b0;
        DIN = (ins[8:6] == 3'd1) ? imm : DW'($urandom);
        #1;
        n = 1;
        while (!Done && n < 6) begin
            @(negedge Clock);
            #1;
            n++;
        end
        chk({tag, "_lat"}, 128'(n), 128'(lat));
        chk({tag, "_bus"}, 128'(Bus), 128'(eb));
        @(negedge Clock);
        #1;
        chk({tag, "_done_once"}, 128'(Done), 128'd0);
        chk({tag, "_cnt"}, 128'(Counter), 128'd0);
        chk({tag, "_regs"}, Rflat, m_flat());
        chk({tag, "_flags"}, 128'(Flags), 128'({m_c, m_z}));
    endtask

    initial begin
        logic [DW-1:0] eb, ins, imm;
        int lat, dn, idle;
        int cexp [6];
        cexp = '{1, 2, 3, 0, 1, 2};

        // reset state
        Reset = 1'b1;
        Run   = 1'b0;
        DIN   = '0;
        m_reset();
        #12;
        chk("rst_cnt", 128'(Counter), 128'd0);
        chk("rst_done", 128'(Done), 128'd0);
        chk("rst_busy", 128'(Busy), 128'd0);
        chk("rst_bus", 128'(Bus), 128'd0);
        chk("rst_clear", 128'(Clear), 128'd1);
        chk("rst_regs", Rflat, 128'd0);
        chk("rst_flags", 128'(Flags), 128'd0);
        @(negedge Clock);
        Reset = 1'b0;

        // 1: mvi R0,5
        exec("t1_mvi", 16'h0040, 16'h0005);
        chk("t1_r0", 128'(Rflat[0 +: DW]), 128'h5);

        // 2: mvi R1,FFFF ; add R0,R1
        exec("t2_mvi", 16'h0048, 16'hFFFF);
        exec("t2_add", 16'h0081, 16'h0000);
        chk("t2_r0", 128'(Rflat[0 +: DW]), 128'h4);
        chk("t2_flags", 128'(Flags), 128'b10);

        // 3: sub R2,R2 ; mvnz (Z=1) ; xor ; mvnz (Z=0)
        exec("t3_sub", 16'h00D2, 16'h0000);
        chk("t3_flags", 128'(Flags), 128'b01);
        exec("t3_mvnz_z", 16'h01D9, 16'h0000);
        chk("t3_r3_kept", 128'(Rflat[3*DW +: DW]), 128'h0);
        exec("t3_xor", 16'h01A1, 16'h0000);
        exec("t3_mvnz", 16'h01D9, 16'h0000);
        chk("t3_r3", 128'(Rflat[3*DW +: DW]), 128'hFFFF);

        // 4: Run held high for 6 cycles with add R0,R1 on DIN
        model(16'h0081, 16'h0, eb, lat);
        @(negedge Clock);
        DIN = 16'h0081;
        Run = 1'b1;
        dn  = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge Clock);
            #1;
            chk("t4_cnt", 128'(Counter), 128'(cexp[k]));
            if (Done) dn++;
            if (k == 2) chk("t4_bus", 128'(Bus), 128'(eb));
        end
        chk("t4_ndone", 128'(dn), 128'd1);
        Run = 1'b0;
        model(16'h0081, 16'h0, eb, lat);
        @(negedge Clock);
        #1;
        chk("t4_done2", 128'(Done), 128'd1);
        chk("t4_bus2", 128'(Bus), 128'(eb));
        @(negedge Clock);
        #1;
        chk("t4_regs", Rflat, m_flat());
        chk("t4_flags", 128'(Flags), 128'({m_c, m_z}));

        // 5: reset in T2 of add R0,R1
        @(negedge Clock);
        DIN = 16'h0081;
        Run = 1'b1;
        @(negedge Clock);
        Run = 1'b0;
        @(negedge Clock);
        #1;
        chk("t5_in_t2", 128'(Counter), 128'd2);
        Reset = 1'b1;
        #1;
        m_reset();
        chk("t5_cnt", 128'(Counter), 128'd0);
        chk("t5_done", 128'(Done), 128'd0);
        chk("t5_bus", 128'(Bus), 128'd0);
        chk("t5_regs", Rflat, 128'd0);
        chk("t5_clear", 128'(Clear), 128'd1);
        @(negedge Clock);
        Reset = 1'b0;
        exec("t5_mvi", 16'h0070, 16'h1234);

        // 6: random instructions with idle gaps
        for (int i = 0; i < 6000; i++) begin
            ins = DW'($urandom);
            imm = DW'($urandom);
            exec("rnd", ins, imm);
            idle = $urandom_range(0, 6);
            for (int k = 0; k < idle; k++) begin
                @(negedge Clock);
                DIN = DW'($urandom);
                #1;
                chk("rnd_idle_done", 128'(Done), 128'd0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
